// File: rtl/gpu_pkg.sv
// Shared definitions for the instruction fetch path: fetch_state encodings and
// the sizing helper for the fetch timeout counter.
package gpu_pkg;

  localparam logic [1:0] FETCH_IDLE     = 2'b00;
  localparam logic [1:0] FETCH_FETCHING = 2'b01;
  localparam logic [1:0] FETCH_FETCHED  = 2'b10;
  localparam logic [1:0] FETCH_ERROR    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = FETCH_IDLE,
    ST_FETCHING = FETCH_FETCHING,
    ST_FETCHED  = FETCH_FETCHED,
    ST_ERROR    = FETCH_ERROR
  } fetch_state_e;

  // Smallest width that can represent n, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/timeout_counter.sv
// Cycle counter for an outstanding fetch; flags the last permitted wait cycle.
// A LIMIT of 0 disables the terminal flag entirely.
module timeout_counter
  import gpu_pkg::*;
#(
  parameter int LIMIT = 255,
  parameter int CNT_W = cnt_width(LIMIT)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'((LIMIT > 0) ? (LIMIT - 1) : 0);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal = (LIMIT > 0) && (count_q == TERM_CNT);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: issues one program-memory read per accepted start,
// holds the result until the core consumes it, and gives up after a timeout.
module fetch_unit
  import gpu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  consume,
  output logic                  mem_read_valid,
  output logic [ADDR_WIDTH-1:0] mem_read_address,
  input  logic                  mem_read_ready,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic [1:0]            fetch_state,
  output logic                  done,
  output logic                  error
);

  fetch_state_e          state_q, state_d;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  cnt_clear;
  logic                  cnt_enable;
  logic                  cnt_terminal;

  timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .terminal (cnt_terminal)
  );

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_FETCHING;
          valid_d   = 1'b1;
          addr_d    = pc;
          cnt_clear = 1'b1;
        end
      end
      ST_FETCHING: begin
        // A response on the terminal cycle still completes the fetch.
        if (mem_read_ready) begin
          state_d = ST_FETCHED;
          valid_d = 1'b0;
          instr_d = mem_read_data;
        end else if (cnt_terminal) begin
          state_d = ST_ERROR;
          valid_d = 1'b0;
        end else begin
          cnt_enable = 1'b1;
        end
      end
      ST_FETCHED, ST_ERROR: begin
        if (consume) begin
          if (start) begin
            state_d   = ST_FETCHING;
            valid_d   = 1'b1;
            addr_d    = pc;
            cnt_clear = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    done_d  = (state_d == ST_FETCHED);
    error_d = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      addr_q  <= '0;
      instr_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign mem_read_valid   = valid_q;
  assign mem_read_address = addr_q;
  assign instruction      = instr_q;
  assign fetch_state      = state_q;
  assign done             = done_q;
  assign error            = error_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a default-timeout instance and a
// TIMEOUT_CYCLES=4 instance share all inputs.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] pc;
  logic        consume;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;

  logic        valid_a, valid_b;
  logic [15:0] addr_a, addr_b;
  logic [15:0] instr_a, instr_b;
  logic [1:0]  state_a, state_b;
  logic        done_a, done_b;
  logic        error_a, error_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .pc               (pc),
    .consume          (consume),
    .mem_read_valid   (valid_a),
    .mem_read_address (addr_a),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .instruction      (instr_a),
    .fetch_state      (state_a),
    .done             (done_a),
    .error            (error_a)
  );

  fetch_unit #(.TIMEOUT_CYCLES(4)) dut4 (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .pc               (pc),
    .consume          (consume),
    .mem_read_valid   (valid_b),
    .mem_read_address (addr_b),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .instruction      (instr_b),
    .fetch_state      (state_b),
    .done             (done_b),
    .error            (error_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pc = 16'h0; consume = 1'b0;
    mem_read_ready = 1'b0; mem_read_data = 16'h0;
    tick(); tick();
    reset = 1'b0;
    check_eq("rst_state", state_a, 2'b00);
    check_eq("rst_valid", valid_a, 0);
    check_eq("rst_addr", addr_a, 16'h0);
    check_eq("rst_instr", instr_a, 16'h0);
    check_eq("rst_done", done_a, 0);
    check_eq("rst_error", error_a, 0);
    check_eq("rst_state4", state_b, 2'b00);

    // Minimum-latency fetch
    start = 1'b1; pc = 16'h0003;
    tick();
    start = 1'b0;
    check_eq("f1_valid", valid_a, 1);
    check_eq("f1_addr", addr_a, 16'h0003);
    check_eq("f1_state", state_a, 2'b01);
    check_eq("f1_done_early", done_a, 0);
    mem_read_ready = 1'b1; mem_read_data = 16'hA5C3;
    tick();
    check_eq("f1_done", done_a, 1);
    check_eq("f1_instr", instr_a, 16'hA5C3);
    check_eq("f1_state_fetched", state_a, 2'b10);
    check_eq("f1_valid_clr", valid_a, 0);
    // Ready outside FETCHING and start without consume are ignored
    mem_read_data = 16'hFFFF; start = 1'b1; pc = 16'h0001;
    tick();
    mem_read_ready = 1'b0; start = 1'b0;
    check_eq("hold_instr", instr_a, 16'hA5C3);
    check_eq("hold_state", state_a, 2'b10);
    consume = 1'b1;
    tick();
    consume = 1'b0;
    check_eq("consume_idle", state_a, 2'b00);
    check_eq("consume_done", done_a, 0);

    // Delayed response with ignored start pulses
    start = 1'b1; pc = 16'h000F;
    tick();
    check_eq("d_valid0", valid_a, 1);
    check_eq("d_addr0", addr_a, 16'h000F);
    for (int i = 0; i < 4; i++) begin
      start = (i % 2 == 0); pc = 16'h0001;
      tick();
      check_eq("d_valid", valid_a, 1);
      check_eq("d_addr", addr_a, 16'h000F);
      check_eq("d_state", state_a, 2'b01);
    end
    start = 1'b0; mem_read_ready = 1'b1; mem_read_data = 16'h1234;
    tick();
    mem_read_ready = 1'b0;
    check_eq("d_done", done_a, 1);
    check_eq("d_instr", instr_a, 16'h1234);
    check_eq("d_state4_err", state_b, 2'b11);

    // Back-to-back fetch from FETCHED (dut) and ERROR (dut4)
    consume = 1'b1; start = 1'b1; pc = 16'h0007;
    tick();
    consume = 1'b0; start = 1'b0;
    check_eq("b2b_state", state_a, 2'b01);
    check_eq("b2b_addr", addr_a, 16'h0007);
    check_eq("b2b_valid", valid_a, 1);
    check_eq("b2b_state4", state_b, 2'b01);
    check_eq("b2b_addr4", addr_b, 16'h0007);
    check_eq("b2b_error4", error_b, 0);
    mem_read_ready = 1'b1; mem_read_data = 16'h0BEE;
    tick();
    mem_read_ready = 1'b0;
    check_eq("b2b_instr", instr_a, 16'h0BEE);
    consume = 1'b1;
    tick();
    consume = 1'b0;

    // Timeout on dut4 with a known prior instruction
    start = 1'b1; pc = 16'h0002;
    tick();
    start = 1'b0; mem_read_ready = 1'b1; mem_read_data = 16'h5A5A;
    tick();
    mem_read_ready = 1'b0; consume = 1'b1;
    tick();
    consume = 1'b0;
    check_eq("t_pre_instr4", instr_b, 16'h5A5A);
    start = 1'b1; pc = 16'h0009;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t_wait_state4", state_b, 2'b01);
      check_eq("t_wait_valid4", valid_b, 1);
    end
    tick();
    check_eq("t_state4", state_b, 2'b11);
    check_eq("t_error4", error_b, 1);
    check_eq("t_valid4", valid_b, 0);
    check_eq("t_done4", done_b, 0);
    check_eq("t_instr4", instr_b, 16'h5A5A);
    check_eq("t_dflt_state", state_a, 2'b01);
    consume = 1'b1;
    tick();
    consume = 1'b0;
    check_eq("t_consume_state4", state_b, 2'b00);
    check_eq("t_consume_error4", error_b, 0);
    check_eq("t_consume_ignored", state_a, 2'b01);

    // Reset mid-fetch abandons the request
    reset = 1'b1;
    tick();
    reset = 1'b0; mem_read_ready = 1'b1; mem_read_data = 16'hFFFF;
    tick();
    mem_read_ready = 1'b0;
    check_eq("r_state", state_a, 2'b00);
    check_eq("r_instr", instr_a, 16'h0000);
    check_eq("r_done", done_a, 0);
    check_eq("r_valid", valid_a, 0);

    // Response on the terminal-count cycle wins
    start = 1'b1; pc = 16'h0004;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check_eq("tc_pre_state4", state_b, 2'b01);
    mem_read_ready = 1'b1; mem_read_data = 16'hC0DE;
    tick();
    mem_read_ready = 1'b0;
    check_eq("tc_state4", state_b, 2'b10);
    check_eq("tc_done4", done_b, 1);
    check_eq("tc_error4", error_b, 0);
    check_eq("tc_instr4", instr_b, 16'hC0DE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 16, meaning program-memory address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, meaning instruction width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum FETCHING cycles before error; 0 disables the timeout.
REQ-004 The block SHALL use one clock, clk; reset SHALL be synchronous and active-high, named reset.
REQ-005 clk  input  1  the single clock; all state changes on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  requests a fetch at pc; sampled only in IDLE, or in FETCHED/ERROR together with consume.
REQ-008 pc  input  ADDR_WIDTH  fetch address, captured on an accepted start.
REQ-009 consume  input  1  the core has taken the instruction or error; releases FETCHED/ERROR.
REQ-010 mem_read_valid  output  1  read request to program memory.
REQ-011 mem_read_address  output  ADDR_WIDTH  registered request address.
REQ-012 mem_read_ready  input  1  memory response strobe; mem_read_data is valid while high.
REQ-013 mem_read_data  input  DATA_WIDTH  instruction word from memory.
REQ-014 instruction  output  DATA_WIDTH  last fetched instruction.
REQ-015 fetch_state  output  2  current state: IDLE=00, FETCHING=01, FETCHED=10, ERROR=11.
REQ-016 done  output  1  high while in FETCHED.
REQ-017 error  output  1  high while in ERROR.

Function
REQ-018 In IDLE with start=1, the block SHALL capture pc into mem_read_address, set mem_read_valid=1 and enter FETCHING on the same edge.
REQ-019 In FETCHING, mem_read_valid SHALL stay 1 and mem_read_address SHALL stay stable until mem_read_ready is sampled high.
REQ-020 On mem_read_ready=1 in FETCHING, the block SHALL register mem_read_data into instruction, clear mem_read_valid and enter FETCHED.
REQ-021 Latency: start sampled at edge 0 SHALL give mem_read_valid=1 after edge 0; ready sampled at edge k (k≥1) SHALL give done=1 and the new instruction after edge k; minimum start-to-done is 2 edges.
REQ-022 In FETCHED, instruction SHALL hold its value; consume=1 SHALL return the block to IDLE.
REQ-023 In FETCHED or ERROR with consume=1 and start=1, the block SHALL go directly to FETCHING with the new pc (back-to-back fetch, no IDLE cycle).
REQ-024 start SHALL be ignored in FETCHING, and in FETCHED/ERROR without consume.
REQ-025 mem_read_ready SHALL be ignored outside FETCHING.
REQ-026 An internal counter SHALL clear on entry to FETCHING and increment each FETCHING cycle without ready; width SHALL be the minimum able to hold TIMEOUT_CYCLES (at least 1 bit).
REQ-027 When TIMEOUT_CYCLES>0 and the counter equals TIMEOUT_CYCLES-1 with ready=0, the block SHALL clear mem_read_valid and enter ERROR; instruction SHALL be unchanged.
REQ-028 If ready=1 on the terminal count cycle, the response SHALL win and the block SHALL enter FETCHED.
REQ-029 In ERROR, consume=1 SHALL return to IDLE and clear error.
REQ-030 pc wider values SHALL not exist; the address SHALL be used unmodified at ADDR_WIDTH bits with no increment or wrap logic in this block.

Reset
REQ-031 reset=1 at an edge SHALL force IDLE, mem_read_valid=0, mem_read_address=0, instruction=0, done=0, error=0 and counter=0, overriding all other inputs.
REQ-032 Reset during FETCHING SHALL abandon the request; a later mem_read_ready SHALL be ignored.

Structure
REQ-033 The fetch_state encodings SHALL be constants in the shared package gpu_pkg.
REQ-034 The timeout counter SHALL be one sub-module, timeout_counter, with clear, enable and terminal-count outputs; all else stays in fetch_unit.

Verification
REQ-035 Reset, then start=1 with pc=0x0003 for 1 cycle, ready=1 with data=0xA5C3 on the next cycle -> valid=1 with addr=0x0003 for 1 cycle, then done=1, instruction=0xA5C3, state=10.
REQ-036 start with pc=0x000F, ready delayed 5 cycles -> valid and addr=0x000F stable for all 5 cycles; start pulses with pc=0x0001 in between are ignored.
REQ-037 TIMEOUT_CYCLES=4, ready never asserted -> ERROR after 4 FETCHING cycles, valid=0, error=1, instruction unchanged; consume -> IDLE.
REQ-038 TIMEOUT_CYCLES=4, ready on the 4th FETCHING cycle -> FETCHED, no error.
REQ-039 In FETCHED, consume=1 and start=1 with pc=0x0007 together -> FETCHING on the next edge with addr=0x0007.
REQ-040 reset asserted in FETCHING, then ready=1 -> state stays IDLE, instruction=0x0000, done=0.
